seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with 1-cycle ops and, with SEQ_ALU_MUL_EN defined, an iterative shift-add MUL.
// Without SEQ_ALU_MUL_EN the MUL opcode behaves as the illegal opcode 111.
module seq_alu #(
  parameter int REG_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           ALU_Operation,
  input  logic [REG_WIDTH-1:0] AC,
  input  logic [REG_WIDTH-1:0] Bus,
  output logic                 busy,
  output logic                 done,
  output logic [REG_WIDTH-1:0] result,
  output logic                 Zflag,
  output logic                 Cflag,
  output logic                 err
);
  localparam logic [2:0] OP_IDLE = 3'b000, OP_PASS = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100, OP_PLUS1 = 3'b101, OP_ZERO = 3'b110, OP_RSVD = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;
  state_t               state_q;
  logic [2:0]           op_q;
  logic [REG_WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic                 z_q, c_q, err_q, done_q, c_d, wr_d, err_d;
  logic [REG_WIDTH:0]   add_w, sub_w, inc_w;
`ifdef SEQ_ALU_MUL_EN
  localparam int CW = $clog2(REG_WIDTH);
  logic [2*REG_WIDTH-1:0] mcand_q, acc_q, acc_d;
  logic [CW-1:0]          cnt_q;
  assign acc_d = acc_q + (b_q[0] ? mcand_q : '0);
`endif
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = res_q;
  assign Zflag  = z_q;
  assign Cflag  = c_q;
  assign err    = err_q;
  always_comb begin
    add_w = {1'b0, a_q} + {1'b0, b_q};
    sub_w = {1'b0, a_q} - {1'b0, b_q};
    inc_w = {1'b0, a_q} + {{REG_WIDTH{1'b0}}, 1'b1};
    res_d = res_q;
    c_d   = c_q;
    wr_d  = 1'b1;
    err_d = (op_q == OP_RSVD) || (op_q == OP_MUL);
    case (op_q)
      OP_PASS:  begin res_d = b_q;                  c_d = 1'b0;             end
      OP_ADD:   begin res_d = add_w[REG_WIDTH-1:0]; c_d = add_w[REG_WIDTH]; end
      OP_SUB:   begin res_d = sub_w[REG_WIDTH-1:0]; c_d = sub_w[REG_WIDTH]; end
      OP_PLUS1: begin res_d = inc_w[REG_WIDTH-1:0]; c_d = inc_w[REG_WIDTH]; end
      OP_ZERO:  begin res_d = '0;                   c_d = 1'b0;             end
      default:  wr_d = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          op_q <= ALU_Operation;
          a_q  <= AC;
          b_q  <= Bus;
`ifdef SEQ_ALU_MUL_EN
          mcand_q <= {{REG_WIDTH{1'b0}}, AC};
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= (ALU_Operation == OP_MUL) ? S_MUL : S_EXEC;
`else
          state_q <= S_EXEC;
`endif
        end
        S_EXEC: begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
          err_q   <= err_d;
          if (wr_d) begin
            res_q <= res_d;
            c_q   <= c_d;
            z_q   <= (res_d == '0);
          end
        end
        default: begin
`ifdef SEQ_ALU_MUL_EN
          // one multiplier bit per cycle; the final iteration commits straight from acc_d
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(REG_WIDTH - 1)) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            res_q   <= acc_d[REG_WIDTH-1:0];
            z_q     <= (acc_d[REG_WIDTH-1:0] == '0);
            c_q     <= |acc_d[2*REG_WIDTH-1:REG_WIDTH];
          end
`else
          state_q <= S_IDLE;
`endif
        end
      endcase
    end
  end
endmodule
